// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, instruction
// classes, opcodes and the select encodings driven onto the datapath.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_JAL
  } class_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_ANDI = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h03;
  localparam logic [5:0] OP_LW   = 6'h04;
  localparam logic [5:0] OP_SW   = 6'h05;
  localparam logic [5:0] OP_BEQ  = 6'h06;
  localparam logic [5:0] OP_J    = 6'h07;
  localparam logic [5:0] OP_JAL  = 6'h08;
  localparam logic [5:0] OP_SLL  = 6'h09;

  localparam logic [1:0] EXT_5  = 2'd0;
  localparam logic [1:0] EXT_14 = 2'd1;
  localparam logic [1:0] EXT_24 = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_SLL = 2'd3;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic TRAP_ILLEGAL = 1'b0;
  localparam logic TRAP_TIMEOUT = 1'b1;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: instruction class plus the immediate-extension
// and ALU selects that the controller latches in DECODE.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       illegal,
  output class_t     op_class,
  output logic       signop,
  output logic [1:0] ext_src,
  output logic [1:0] alu_op,
  output logic       alu_src_b
);

  // Map each opcode to its class and datapath selects; unknown opcodes are illegal.
  always_comb begin
    illegal   = 1'b0;
    op_class  = CL_ALU;
    signop    = 1'b0;
    ext_src   = EXT_5;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    case (opcode)
      OP_ADD: ;
      OP_SUB: alu_op = ALU_SUB;
      OP_ANDI: begin
        ext_src   = EXT_14;
        alu_op    = ALU_AND;
        alu_src_b = 1'b1;
      end
      OP_ADDI: begin
        ext_src   = EXT_14;
        signop    = 1'b1;
        alu_src_b = 1'b1;
      end
      OP_LW, OP_SW: begin
        op_class  = (opcode == OP_LW) ? CL_LOAD : CL_STORE;
        ext_src   = EXT_14;
        signop    = 1'b1;
        alu_src_b = 1'b1;
      end
      OP_BEQ: begin
        op_class = CL_BRANCH;
        ext_src  = EXT_14;
        signop   = 1'b1;
        alu_op   = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        op_class = (opcode == OP_J) ? CL_JUMP : CL_JAL;
        ext_src  = EXT_24;
        signop   = 1'b1;
      end
      OP_SLL: begin
        ext_src   = EXT_5;
        alu_op    = ALU_SLL;
        alu_src_b = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], with a
// watchdog on the memory handshake and a sticky TRAP state.
// Optional cycle/retire counters are built when CTRL_PERF_COUNTERS_EN is defined.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        signop,
  output logic [1:0]  ext_src,
  output logic [2:0]  state,
  output logic        trap,
  output logic        trap_cause
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_WAIT_MAX - 1);

  state_t      state_q, state_d;
  class_t      class_q, class_d;
  logic        signop_q, signop_d;
  logic [1:0]  ext_src_q, ext_src_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        alu_src_b_q, alu_src_b_d;
  logic        trap_q, trap_d;
  logic        trap_cause_q, trap_cause_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic        dec_illegal;
  class_t      dec_class;
  logic        dec_signop;
  logic [1:0]  dec_ext_src;
  logic [1:0]  dec_alu_op;
  logic        dec_alu_src_b;
  logic        mem_phase;
  logic        timeout;

  ctrl_decoder u_decoder (
    .opcode    (opcode),
    .illegal   (dec_illegal),
    .op_class  (dec_class),
    .signop    (dec_signop),
    .ext_src   (dec_ext_src),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_alu_src_b)
  );

  // Watchdog fires on the MEM_WAIT_MAX-th consecutive not-ready cycle of an access.
  assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout   = mem_phase && !mem_ready && (wait_cnt_q == WAIT_LAST);

  // State and latched-decode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      class_q      <= CL_ALU;
      signop_q     <= 1'b0;
      ext_src_q    <= EXT_5;
      alu_op_q     <= ALU_ADD;
      alu_src_b_q  <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      signop_q     <= signop_d;
      ext_src_q    <= ext_src_d;
      alu_op_q     <= alu_op_d;
      alu_src_b_q  <= alu_src_b_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Next-state sequencing per phase; TRAP absorbs until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_TRAP;
      end
      ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (class_q)
          CL_LOAD, CL_STORE:         state_d = ST_MEM;
          CL_BRANCH, CL_JUMP, CL_JAL: state_d = ST_FETCH;
          default:                   state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)    state_d = (class_q == CL_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout) state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Decode latch, trap capture and wait-counter update.
  always_comb begin
    class_d      = class_q;
    signop_d     = signop_q;
    ext_src_d    = ext_src_q;
    alu_op_d     = alu_op_q;
    alu_src_b_d  = alu_src_b_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    wait_cnt_d   = wait_cnt_q;
    if (state_q == ST_DECODE) begin
      class_d     = dec_class;
      signop_d    = dec_signop;
      ext_src_d   = dec_ext_src;
      alu_op_d    = dec_alu_op;
      alu_src_b_d = dec_alu_src_b;
    end
    if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
      trap_d       = 1'b1;
      trap_cause_d = (state_q == ST_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
    end
    if (mem_phase && !mem_ready) wait_cnt_d = wait_cnt_q + 16'd1;
    // Entering an access phase restarts the count, overriding the increment above.
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)))
      wait_cnt_d = '0;
  end

  // Datapath enables from the current state; held inactive while reset is asserted.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PC4;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_EXEC: begin
          case (class_q)
            CL_BRANCH: begin
              pc_write = zero;
              pc_src   = PC_SRC_BRANCH;
            end
            CL_JUMP: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
            end
            CL_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              reg_write = 1'b1;
              wb_sel    = WB_PC;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_read  = (class_q == CL_LOAD);
          mem_write = (class_q == CL_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_sel    = (class_q == CL_LOAD) ? WB_MEM : WB_ALU;
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign signop     = signop_q;
  assign ext_src    = ext_src_q;
  assign alu_op     = alu_op_q;
  assign alu_src_b  = alu_src_b_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Count live cycles and instruction completions (any return to FETCH); frozen in TRAP.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (state_q != ST_TRAP) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if ((state_d == ST_FETCH) && (state_q != ST_FETCH))
        retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level trace model
// produces the expected per-cycle outputs, driven by a directed table, hand
// sequences for traps/reset, and randomized instruction streams.
module tb_multicycle_ctrl;

  localparam int unsigned MAXW = 4;
  localparam logic [13:0] FULL = 14'h3FFF;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  opcode;
  logic        ir_write, pc_write, mem_read, mem_write, reg_write;
  logic [1:0]  pc_src, wb_sel, alu_op, ext_src;
  logic        alu_src_b, signop, trap, trap_cause;
  logic [2:0]  state;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .signop     (signop),
    .ext_src    (ext_src),
    .state      (state),
    .trap       (trap),
    .trap_cause (trap_cause)
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  // One expected clock cycle: inputs to drive and masked expected outputs.
  // ctl = {state[2:0], ir_write, pc_write, pc_src[1:0], mem_read, mem_write,
  //        reg_write, wb_sel[1:0], trap, trap_cause}
  // sel = {signop, ext_src[1:0], alu_op[1:0], alu_src_b}
  typedef struct {
    logic        rst;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [13:0] ctl;
    logic [13:0] ctl_m;
    logic [5:0]  sel;
    logic [5:0]  sel_m;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fd;
    int         md;
    logic [5:0] sel;
    logic [5:0] selm;
  } vec_t;

  exp_t        q[$];
  vec_t        tv[12];
  logic [5:0]  m_sel, m_selm;
  int unsigned n_pass, n_total, n_cyc;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [13:0] mk(input int st, input bit irw, input bit pcw,
                                     input int pcs, input bit mrd, input bit mwr,
                                     input bit rw, input int wbs, input bit tr,
                                     input bit tc);
    return {st[2:0], irw, pcw, pcs[1:0], mrd, mwr, rw, wbs[1:0], tr, tc};
  endfunction

  // Instruction semantics: kind 0=ALU/WB, 1=LW, 2=SW, 3=BEQ, 4=J, 5=JAL, -1=illegal.
  // selm marks which select fields the instruction defines.
  task automatic spec_fields(input logic [5:0] op, output int kind,
                             output logic [5:0] sel, output logic [5:0] selm);
    case (op)
      6'h00:        begin kind = 0; sel = {1'b0, 2'd0, 2'd0, 1'b0}; selm = 6'b000111; end
      6'h01:        begin kind = 0; sel = {1'b0, 2'd0, 2'd1, 1'b0}; selm = 6'b000111; end
      6'h02:        begin kind = 0; sel = {1'b0, 2'd1, 2'd2, 1'b1}; selm = 6'b111111; end
      6'h03:        begin kind = 0; sel = {1'b1, 2'd1, 2'd0, 1'b1}; selm = 6'b111111; end
      6'h04:        begin kind = 1; sel = {1'b1, 2'd1, 2'd0, 1'b1}; selm = 6'b111111; end
      6'h05:        begin kind = 2; sel = {1'b1, 2'd1, 2'd0, 1'b1}; selm = 6'b111111; end
      6'h06:        begin kind = 3; sel = {1'b1, 2'd1, 2'd1, 1'b0}; selm = 6'b111110; end
      6'h07:        begin kind = 4; sel = {1'b1, 2'd2, 2'd0, 1'b0}; selm = 6'b111000; end
      6'h08:        begin kind = 5; sel = {1'b1, 2'd2, 2'd0, 1'b0}; selm = 6'b111000; end
      6'h09:        begin kind = 0; sel = {1'b0, 2'd0, 2'd3, 1'b1}; selm = 6'b111111; end
      default:      begin kind = -1; sel = 6'd0; selm = 6'd0; end
    endcase
  endtask

  task automatic push(input logic rst, input logic mr, input logic z, input logic [5:0] op,
                      input logic [13:0] ctl, input logic [13:0] ctl_m);
    exp_t e;
    e.rst = rst; e.mr = mr; e.z = z; e.op = op;
    e.ctl = ctl; e.ctl_m = ctl_m; e.sel = m_sel; e.sel_m = m_selm;
    q.push_back(e);
  endtask

  task automatic push_trap(input logic [5:0] op, input bit cause);
    for (int i = 0; i < 3; i++)
      push(1'b0, rb(), rb(), op, mk(5, 0, 0, 0, 0, 0, 0, 0, 1, cause), FULL);
  endtask

  // Two reset cycles: the first only checks enables (state still pre-reset),
  // the second checks the full cleared state.
  task automatic model_reset();
    m_selm = 6'd0;
    push(1'b1, rb(), rb(), 6'h00, 14'd0, 14'h07FC);
    m_sel  = 6'd0;
    m_selm = 6'h3F;
    push(1'b1, rb(), rb(), 6'h00, 14'd0, FULL);
  endtask

  // Expected cycle trace of one instruction; fd/md = not-ready cycles before
  // mem_ready in FETCH/MEM (>= MAXW means the watchdog expires).
  task automatic model_instr(input logic [5:0] op, input logic z, input int fd, input int md);
    int kind;
    logic [5:0] s, sm;
    spec_fields(op, kind, s, sm);
    for (int i = 0; i < fd && i < int'(MAXW); i++)
      push(1'b0, 1'b0, rb(), op, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), FULL);
    if (fd >= int'(MAXW)) begin push_trap(op, 1); return; end
    push(1'b0, 1'b1, rb(), op, mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0), FULL);
    push(1'b0, rb(), rb(), op, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), FULL);
    if (kind < 0) begin m_selm = 6'd0; push_trap(op, 0); return; end
    m_sel  = s;
    m_selm = sm;
    case (kind)
      3:       push(1'b0, rb(), z, op, mk(2, 0, z, 1, 0, 0, 0, 0, 0, 0), FULL);
      4:       push(1'b0, rb(), rb(), op, mk(2, 0, 1, 2, 0, 0, 0, 0, 0, 0), FULL);
      5:       push(1'b0, rb(), rb(), op, mk(2, 0, 1, 2, 0, 0, 1, 2, 0, 0), FULL);
      default: push(1'b0, rb(), rb(), op, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), FULL);
    endcase
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i < md && i < int'(MAXW); i++)
        push(1'b0, 1'b0, rb(), op, mk(3, 0, 0, 0, kind == 1, kind == 2, 0, 0, 0, 0), FULL);
      if (md >= int'(MAXW)) begin push_trap(op, 1); return; end
      push(1'b0, 1'b1, rb(), op, mk(3, 0, 0, 0, kind == 1, kind == 2, 0, 0, 0, 0), FULL);
      if (kind == 1)
        push(1'b0, rb(), rb(), op, mk(4, 0, 0, 0, 0, 0, 1, 1, 0, 0), FULL);
    end else if (kind == 0) begin
      push(1'b0, rb(), rb(), op, mk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0), FULL);
    end
  endtask

  task automatic truncate(input int keep);
    while (q.size() > keep) q.delete(q.size() - 1);
  endtask

  // Apply queued cycles: drive at negedge, compare shortly after.
  task automatic run();
    exp_t e;
    logic [13:0] act;
    logic [5:0]  acts;
    while (q.size() != 0) begin
      e = q.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z; opcode = e.op;
      #2;
      act  = {state, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
              wb_sel, trap, trap_cause};
      acts = {signop, ext_src, alu_op, alu_src_b};
      n_total++;
      if (((act & e.ctl_m) == (e.ctl & e.ctl_m)) && ((acts & e.sel_m) == (e.sel & e.sel_m)))
        n_pass++;
      else
        $display("FAIL cycle %0d op=%h: ctl got %h want %h (mask %h), sel got %h want %h (mask %h)",
                 n_cyc, e.op, act, e.ctl, e.ctl_m, acts, e.sel, e.sel_m);
      n_cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    logic [5:0] acts, rop;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00;
    n_pass = 0; n_total = 0; n_cyc = 0;
    m_sel = 6'd0; m_selm = 6'd0;

    tv[0]  = '{6'h03, 1'b0, 0, 0, {1'b1, 2'd1, 2'd0, 1'b1}, 6'h3F};
    tv[1]  = '{6'h04, 1'b0, 0, 3, {1'b1, 2'd1, 2'd0, 1'b1}, 6'h3F};
    tv[2]  = '{6'h06, 1'b1, 0, 0, {1'b1, 2'd1, 2'd1, 1'b0}, 6'h3E};
    tv[3]  = '{6'h06, 1'b0, 1, 0, {1'b1, 2'd1, 2'd1, 1'b0}, 6'h3E};
    tv[4]  = '{6'h07, 1'b0, 0, 0, {1'b1, 2'd2, 2'd0, 1'b0}, 6'h38};
    tv[5]  = '{6'h09, 1'b0, 2, 0, {1'b0, 2'd0, 2'd3, 1'b1}, 6'h3F};
    tv[6]  = '{6'h00, 1'b0, 3, 0, {1'b0, 2'd0, 2'd0, 1'b0}, 6'h07};
    tv[7]  = '{6'h01, 1'b1, 0, 0, {1'b0, 2'd0, 2'd1, 1'b0}, 6'h07};
    tv[8]  = '{6'h02, 1'b0, 0, 0, {1'b0, 2'd1, 2'd2, 1'b1}, 6'h3F};
    tv[9]  = '{6'h05, 1'b0, 0, 2, {1'b1, 2'd1, 2'd0, 1'b1}, 6'h3F};
    tv[10] = '{6'h08, 1'b0, 0, 0, {1'b1, 2'd2, 2'd0, 1'b0}, 6'h38};
    tv[11] = '{6'h04, 1'b0, 3, 3, {1'b1, 2'd1, 2'd0, 1'b1}, 6'h3F};

    model_reset();
    run();

    // Directed table: full cycle trace plus latched selects after completion.
    for (int i = 0; i < 12; i++) begin
      model_instr(tv[i].op, tv[i].z, tv[i].fd, tv[i].md);
      run();
      acts = {signop, ext_src, alu_op, alu_src_b};
      n_total++;
      if ((acts & tv[i].selm) == (tv[i].sel & tv[i].selm)) n_pass++;
      else $display("FAIL table[%0d] selects: got %h want %h (mask %h)",
                    i, acts, tv[i].sel, tv[i].selm);
    end

    // Illegal opcodes trap after DECODE and stay trapped.
    model_instr(6'h3F, 1'b0, 0, 0); run();
    model_reset(); run();
    model_instr(6'h0A, 1'b0, 1, 0); run();
    model_reset(); run();

    // Watchdog expiry in FETCH and in MEM.
    model_instr(6'h00, 1'b0, MAXW, 0); run();
    model_reset(); run();
    model_instr(6'h04, 1'b0, 0, MAXW); run();
    model_reset(); run();

    // Reset mid-FETCH wait, then a normal instruction restarts cleanly.
    n = q.size();
    model_instr(6'h00, 1'b0, MAXW, 0);
    truncate(n + 2);
    model_reset();
    model_instr(6'h03, 1'b0, 0, 0);
    run();

    // Reset mid-MEM store wait.
    n = q.size();
    model_instr(6'h05, 1'b0, 0, 3);
    truncate(n + 4);
    model_reset();
    model_instr(6'h04, 1'b0, 1, 1);
    run();

    // Randomized instruction stream; occasional illegal opcode followed by reset.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        rop = 6'($urandom_range(10, 63));
        model_instr(rop, rb(), $urandom_range(0, 3), 0);
        model_reset();
      end else begin
        rop = 6'($urandom_range(0, 9));
        model_instr(rop, rb(), $urandom_range(0, MAXW - 1), $urandom_range(0, MAXW - 1));
      end
      run();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
